// File: rtl/smart_led_frame_select.sv
// Smart-LED frame selector: claims the first NUM_CH marked words of a frame, checks their parity,
// latches their payloads for the PWM stage and forwards the stream with those markers cleared.
module smart_led_frame_select #(
   parameter int WORD_W   = 32,
   parameter int NUM_CH   = 1,
   parameter int PAR_MODE = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_data,
   input  logic                         in_clk,
   input  logic                         in_sync,
   output logic                         out_data,
   output logic                         out_clk,
   output logic [NUM_CH*(WORD_W-2)-1:0] pwm_data,
   output logic                         pwm_set,
   output logic                         error
);

   localparam int P    = WORD_W - 2;
   localparam int BC_W = $clog2(WORD_W);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {HUNT, CAP, NEXT, DONE} state_t;

   state_t                state;
   logic [BC_W-1:0]       bit_cnt;
   logic [CH_W-1:0]       ch_cnt;
   logic [NUM_CH*P-1:0]   shadow;
   logic [P-1:0]          cur_word;
   logic                  par_acc;
   logic                  latch_pend;
   logic                  bit_stb;
   logic                  is_first;
   logic                  is_par;
   logic                  swap;

   // par_acc is the XOR of the payload bits received so far for the word in capture.
   function automatic logic parity_ok(input logic acc, input logic pbit);
      case (PAR_MODE)
         0:       return (acc == pbit);
         1:       return (acc != pbit);
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      bit_stb  = in_sync & in_clk & ~error;
      is_first = (bit_cnt == '0);
      is_par   = (bit_cnt == BC_W'(WORD_W - 1));
      cur_word = shadow[ch_cnt*P +: P];
      swap     = bit_stb & is_first & in_data & ((state == HUNT) || (state == NEXT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= 1'b0;
         out_clk    <= 1'b0;
         pwm_data   <= '0;
         pwm_set    <= 1'b0;
         error      <= 1'b0;
         state      <= HUNT;
         bit_cnt    <= '0;
         ch_cnt     <= '0;
         shadow     <= '0;
         par_acc    <= 1'b0;
         latch_pend <= 1'b0;
      end else begin
         pwm_set    <= 1'b0;
         latch_pend <= 1'b0;
         // The last parity bit was accepted on the previous cycle; shadow is complete.
         if (latch_pend) begin
            pwm_data <= shadow;
            pwm_set  <= 1'b1;
         end
         if (!in_sync) begin
            out_clk  <= in_clk;
            out_data <= in_data;
            state    <= HUNT;
            bit_cnt  <= '0;
            ch_cnt   <= '0;
            error    <= 1'b0;
            par_acc  <= 1'b0;
         end else begin
            out_clk  <= in_clk & ~error;
            out_data <= in_data ^ swap;
            if (bit_stb) begin
               bit_cnt <= is_par ? '0 : bit_cnt + 1'b1;
               case (state)
                  HUNT: begin
                     if (is_first && in_data) begin
                        state  <= CAP;
                        ch_cnt <= '0;
                     end
                  end
                  CAP: begin
                     if (is_par) begin
                        par_acc <= 1'b0;
                        if (!parity_ok(par_acc, in_data)) begin
                           error <= 1'b1;
                        end else if (ch_cnt == CH_W'(NUM_CH - 1)) begin
                           state      <= DONE;
                           latch_pend <= 1'b1;
                        end else begin
                           ch_cnt <= ch_cnt + 1'b1;
                           state  <= NEXT;
                        end
                     end else begin
                        shadow[ch_cnt*P +: P] <= {cur_word[P-2:0], in_data};
                        par_acc               <= par_acc ^ in_data;
                     end
                  end
                  NEXT: begin
                     if (is_first) begin
                        if (in_data) state <= CAP;
                        else         error <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
